// File: rtl/data_sram_responder.sv
`default_nettype none
// ============================================================================
// data_sram_responder : CPU data-SRAM slave (word RAM + confreg block).
// Optional macro CONFREG_TIMER_CMP_EN adds COMPARE/timer_int.  Rev 1.0
// ============================================================================
module data_sram_responder #(
  parameter int ADDR_W     = 12,
  parameter bit SIMULATION = 1'b0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        data_sram_en,
  input  logic [3:0]  data_sram_wen,
  input  logic [31:0] data_sram_addr,
  input  logic [31:0] data_sram_wdata,
  output logic [31:0] data_sram_rdata,
  output logic [15:0] led,
  input  logic [7:0]  switch,
  output logic        timer_int
);

  localparam logic [15:0] C_CONF_BASE = 16'hbfaf;

  logic [31:0]       mem [2**ADDR_W];
  logic [31:0]       rdata_q;
  logic [31:0]       cr_q [8];
  logic [15:0]       led_q;
  logic [31:0]       timer_q;
  logic [31:0]       timer_d;
  logic [7:0]        sw_meta_q;
  logic [7:0]        sw_sync_q;

  logic              w_conf;
  logic              w_wr;
  logic              w_wr_conf;
  logic              w_wr_ram;
  logic [15:0]       w_off;
  logic [ADDR_W-1:0] w_idx;
  logic [2:0]        w_cr_idx;
  logic [31:0]       w_mask;
  logic              w_hit_cr;
  logic              w_hit_timer;
  logic              w_hit_cmp;
  logic              w_hit_led;
  logic              w_hit_sw;
  logic              w_hit_simu;
  logic [31:0]       w_cmp_rd;
  logic [31:0]       w_conf_rd;

  function automatic logic [31:0] merge(input logic [31:0] old_v,
                                        input logic [31:0] new_v,
                                        input logic [31:0] mask);
    return (old_v & ~mask) | (new_v & mask);
  endfunction

  assign w_conf    = (data_sram_addr[31:16] == C_CONF_BASE);
  assign w_off     = {data_sram_addr[15:2], 2'b00};
  assign w_idx     = data_sram_addr[ADDR_W+1:2];
  assign w_cr_idx  = data_sram_addr[4:2];
  assign w_wr      = data_sram_en && (data_sram_wen != 4'b0000);
  assign w_wr_conf = w_wr && w_conf;
  assign w_wr_ram  = w_wr && !w_conf && !reset;
  assign w_mask    = {{8{data_sram_wen[3]}}, {8{data_sram_wen[2]}},
                      {8{data_sram_wen[1]}}, {8{data_sram_wen[0]}}};

  assign w_hit_cr    = (w_off[15:5] == 11'h400);
  assign w_hit_timer = (w_off == 16'he000);
  assign w_hit_cmp   = (w_off == 16'he004);
  assign w_hit_led   = (w_off == 16'hf000);
  assign w_hit_sw    = (w_off == 16'hf020);
  assign w_hit_simu  = (w_off == 16'hf030);

  always_comb begin
    w_conf_rd = 32'h0;
    if (w_hit_cr)         w_conf_rd = cr_q[w_cr_idx];
    else if (w_hit_timer) w_conf_rd = timer_q;
    else if (w_hit_cmp)   w_conf_rd = w_cmp_rd;
    else if (w_hit_led)   w_conf_rd = {16'h0, led_q};
    else if (w_hit_sw)    w_conf_rd = {24'h0, sw_sync_q};
    else if (w_hit_simu)  w_conf_rd = {32{SIMULATION}};
  end

  // A same-cycle TIMER write overrides the increment.
  always_comb begin
    timer_d = timer_q + 32'd1;
    if (w_wr_conf && w_hit_timer) timer_d = merge(timer_q, data_sram_wdata, w_mask);
  end

  // RAM is never reset; only the write port is gated by reset.
  always_ff @(posedge clk) begin
    if (w_wr_ram) begin
      for (int i = 0; i < 4; i++) begin
        if (data_sram_wen[i]) mem[w_idx][8*i +: 8] <= data_sram_wdata[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rdata_q   <= 32'h0;
      led_q     <= 16'h0;
      timer_q   <= 32'h0;
      sw_meta_q <= 8'h0;
      sw_sync_q <= 8'h0;
      for (int i = 0; i < 8; i++) cr_q[i] <= 32'h0;
    end else begin
      sw_meta_q <= switch;
      sw_sync_q <= sw_meta_q;
      timer_q   <= timer_d;
      if (data_sram_en) rdata_q <= w_conf ? w_conf_rd : mem[w_idx];
      if (w_wr_conf && w_hit_cr)
        cr_q[w_cr_idx] <= merge(cr_q[w_cr_idx], data_sram_wdata, w_mask);
      if (w_wr_conf && w_hit_led)
        led_q <= merge({16'h0, led_q}, data_sram_wdata, w_mask) >> 0 & 32'h0000ffff;
    end
  end

`ifdef CONFREG_TIMER_CMP_EN
  logic [31:0] cmp_q;
  logic        tint_q;

  // A COMPARE write clears the interrupt even if a match happens that cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      cmp_q  <= 32'hffffffff;
      tint_q <= 1'b0;
    end else if (w_wr_conf && w_hit_cmp) begin
      cmp_q  <= merge(cmp_q, data_sram_wdata, w_mask);
      tint_q <= 1'b0;
    end else if (timer_q == cmp_q) begin
      tint_q <= 1'b1;
    end
  end

  assign w_cmp_rd  = cmp_q;
  assign timer_int = tint_q;
`else
  assign w_cmp_rd  = 32'h0;
  assign timer_int = 1'b0;
`endif

  assign data_sram_rdata = rdata_q;
  assign led             = led_q;

endmodule
`default_nettype wire

// File: tb/tb_data_sram_responder.sv
`default_nettype none
// ============================================================================
// tb_data_sram_responder : randomized + directed bench with behavioural model.
// Honours CONFREG_TIMER_CMP_EN the same way as the design.  Rev 1.0
// ============================================================================
module tb_data_sram_responder;
  localparam int ADDR_W = 12;
`ifdef CONFREG_TIMER_CMP_EN
  localparam bit HAS_CMP = 1'b1;
`else
  localparam bit HAS_CMP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        en = 1'b0;
  logic [3:0]  wen = 4'h0;
  logic [31:0] addr = 32'h0;
  logic [31:0] wdata = 32'h0;
  logic [31:0] rdata;
  logic [15:0] led;
  logic [7:0]  sw = 8'h0;
  logic        tint;

  int vectors = 0;
  int miscompares = 0;

  data_sram_responder #(.ADDR_W(ADDR_W), .SIMULATION(1'b1)) dut (
    .clk(clk), .reset(reset), .data_sram_en(en), .data_sram_wen(wen),
    .data_sram_addr(addr), .data_sram_wdata(wdata), .data_sram_rdata(rdata),
    .led(led), .switch(sw), .timer_int(tint)
  );

  always #5 clk = ~clk;

  // ---------------- behavioural model ----------------
  logic        m_valid = 1'b0;
  logic [31:0] m_rd = 32'h0;
  logic        m_rd_known = 1'b0;
  logic [15:0] m_led;
  logic [31:0] m_cr [8];
  logic [31:0] m_timer;
  logic [31:0] m_cmp;
  logic        m_tint;
  logic [7:0]  sw_d1, sw_d2;
  logic [31:0] mram [int];
  logic [31:0] m_off, m_rv;
  logic        m_rk, m_conf, m_wr;
  int          m_idx;

  function automatic logic [31:0] lanes(input logic [31:0] old_v, input logic [31:0] new_v,
                                        input logic [3:0] w);
    logic [31:0] r = old_v;
    for (int i = 0; i < 4; i++) if (w[i]) r[8*i +: 8] = new_v[8*i +: 8];
    return r;
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      m_valid = 1'b1; m_rd = 32'h0; m_rd_known = 1'b1; m_led = 16'h0;
      for (int i = 0; i < 8; i++) m_cr[i] = 32'h0;
      m_timer = 32'h0; m_cmp = 32'hffffffff; m_tint = 1'b0; sw_d1 = 8'h0; sw_d2 = 8'h0;
    end else begin
      m_conf = (addr[31:16] == 16'hbfaf);
      m_off  = {16'h0, addr[15:2], 2'b00};
      m_idx  = int'(addr[ADDR_W+1:2]);
      m_wr   = en && (wen != 4'h0);
      m_rk = 1'b1; m_rv = 32'h0;
      if (m_conf) begin
        if (m_off >= 32'h8000 && m_off <= 32'h801c) m_rv = m_cr[(m_off - 32'h8000) / 4];
        else if (m_off == 32'he000) m_rv = m_timer;
        else if (m_off == 32'he004) m_rv = HAS_CMP ? m_cmp : 32'h0;
        else if (m_off == 32'hf000) m_rv = {16'h0, m_led};
        else if (m_off == 32'hf020) m_rv = {24'h0, sw_d2};
        else if (m_off == 32'hf030) m_rv = 32'hffffffff;
      end else if (mram.exists(m_idx)) m_rv = mram[m_idx];
      else m_rk = 1'b0;
      if (en) begin m_rd = m_rv; m_rd_known = m_rk; end
      if (HAS_CMP) begin
        if (m_wr && m_conf && m_off == 32'he004) m_tint = 1'b0;
        else if (m_timer == m_cmp) m_tint = 1'b1;
      end
      if (m_wr && m_conf && m_off == 32'he000) m_timer = lanes(m_timer, wdata, wen);
      else m_timer = m_timer + 32'd1;
      if (m_wr && m_conf) begin
        if (m_off >= 32'h8000 && m_off <= 32'h801c)
          m_cr[(m_off - 32'h8000) / 4] = lanes(m_cr[(m_off - 32'h8000) / 4], wdata, wen);
        else if (m_off == 32'hf000) m_led = lanes({16'h0, m_led}, wdata, wen) & 32'hffff;
        else if (m_off == 32'he004 && HAS_CMP) m_cmp = lanes(m_cmp, wdata, wen);
      end else if (m_wr) begin
        if (mram.exists(m_idx)) mram[m_idx] = lanes(mram[m_idx], wdata, wen);
        else if (wen == 4'hf) mram[m_idx] = wdata;
      end
      sw_d2 = sw_d1; sw_d1 = sw;
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %08h expected %08h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (m_valid) begin
      if (m_rd_known) chk("rdata", rdata, m_rd);
      chk("led", {16'h0, led}, {16'h0, m_led});
      chk("timer_int", {31'h0, tint}, {31'h0, m_tint});
    end
  end

  // ---------------- stimulus ----------------
  task automatic acc(input logic e, input logic [3:0] w, input logic [31:0] a, input logic [31:0] d);
    en = e; wen = w; addr = a; wdata = d;
    @(posedge clk); #1;
  endtask

  logic [ADDR_W-1:0] pool [16];
  logic [31:0]       ra, up;
  int                sel;

  initial begin
    for (int i = 0; i < 16; i++) pool[i] = ADDR_W'(i * 16 + 16);
    acc(0, 4'h0, 32'h0, 32'h0);
    acc(0, 4'h0, 32'h0, 32'h0);
    reset = 1'b0;
    chk("reset_rdata", rdata, 32'h0);
    chk("reset_led", {16'h0, led}, 32'h0);
    chk("reset_tint", {31'h0, tint}, 32'h0);
    for (int i = 0; i < 16; i++) acc(1, 4'hf, 32'(pool[i]) << 2, 32'h0);

    acc(1, 4'hf, 32'h40, 32'h12345678);
    acc(1, 4'b0010, 32'h40, 32'h0000AB00);
    acc(1, 4'h0, 32'h40, 32'h0);
    chk("ram_merge", rdata, 32'h1234AB78);

    acc(1, 4'hf, 32'h100, 32'hDEADBEEF);
    chk("read_first", rdata, 32'h0);
    acc(1, 4'h0, 32'h100, 32'h0);
    chk("b2b_read", rdata, 32'hDEADBEEF);
    for (int i = 0; i < 3; i++) begin
      acc(0, 4'h0, 32'h0, 32'h0);
      chk("rdata_hold", rdata, 32'hDEADBEEF);
    end

    acc(1, 4'hf, 32'hbfafe000, 32'hfffffffe);
    acc(0, 4'h0, 32'h0, 32'h0);
    acc(1, 4'h0, 32'hbfafe000, 32'h0);
    chk("timer_pre_wrap", rdata, 32'hffffffff);
    acc(1, 4'h0, 32'hbfafe000, 32'h0);
    chk("timer_wrap", rdata, 32'h0);

    acc(1, 4'hf, 32'hbfaff000, 32'h0000A5A5);
    chk("led_out", {16'h0, led}, 32'h0000A5A5);
    acc(1, 4'hf, 32'hbfaff020, 32'hffffffff);
    acc(1, 4'h0, 32'hbfaff020, 32'h0);
    chk("switch_ro", rdata, 32'h0);
    acc(1, 4'h0, 32'hbfafff00, 32'h0);
    chk("unmapped", rdata, 32'h0);
    acc(1, 4'h0, 32'hbfaff030, 32'h0);
    chk("simu_flag", rdata, 32'hffffffff);
    sw = 8'h3C;
    acc(1, 4'h0, 32'hbfaff020, 32'h0);
    chk("switch_c0", rdata, 32'h0);
    acc(1, 4'h0, 32'hbfaff020, 32'h0);
    chk("switch_c1", rdata, 32'h0);
    acc(1, 4'h0, 32'hbfaff020, 32'h0);
    chk("switch_c2", rdata, 32'h3C);

    acc(1, 4'hf, 32'hbfafe000, 32'h1000);
    acc(1, 4'hf, 32'hbfafe004, 32'h20);
    chk("cmp_clear", {31'h0, tint}, 32'h0);
    acc(1, 4'h0, 32'hbfafe004, 32'h0);
    chk("cmp_read", rdata, HAS_CMP ? 32'h20 : 32'h0);
    acc(1, 4'hf, 32'hbfafe000, 32'h1e);
    acc(0, 4'h0, 32'h0, 32'h0);
    chk("tint_c1", {31'h0, tint}, 32'h0);
    acc(0, 4'h0, 32'h0, 32'h0);
    chk("tint_c2", {31'h0, tint}, 32'h0);
    acc(0, 4'h0, 32'h0, 32'h0);
    chk("tint_c3", {31'h0, tint}, HAS_CMP ? 32'h1 : 32'h0);
    acc(1, 4'hf, 32'hbfafe004, 32'hffffffff);
    chk("tint_fall", {31'h0, tint}, 32'h0);

    acc(1, 4'hf, 32'(pool[5]) << 2, 32'hCAFEF00D);
    acc(1, 4'hf, 32'hbfaff000, 32'h1234);
    reset = 1'b1;
    acc(1, 4'hf, 32'hbfaf800c, 32'h55);
    reset = 1'b0;
    chk("rst_led", {16'h0, led}, 32'h0);
    chk("rst_rdata", rdata, 32'h0);
    acc(1, 4'h0, 32'hbfafe000, 32'h0);
    chk("rst_timer", rdata, 32'h0);
    acc(1, 4'h0, 32'hbfaf800c, 32'h0);
    chk("rst_cr3", rdata, 32'h0);
    acc(1, 4'h0, 32'(pool[5]) << 2, 32'h0);
    chk("rst_ram_keep", rdata, 32'hCAFEF00D);

    for (int n = 0; n < 1500; n++) begin
      reset = ($urandom_range(0, 149) == 0);
      if ($urandom_range(0, 7) == 0) sw = 8'($urandom);
      sel = $urandom_range(0, 1);
      if (sel == 0) begin
        up = $urandom;
        if (up[31:16] == 16'hbfaf) up[31:16] = 16'h0;
        ra = up;
        ra[ADDR_W+1:2] = pool[$urandom_range(0, 15)];
      end else begin
        sel = $urandom_range(0, 13);
        ra = 32'hbfaf0000 | 32'($urandom_range(0, 3));
        if (sel < 8) ra[15:2] = 14'((32'h8000 + 32'(sel) * 4) >> 2);
        else if (sel == 8) ra[15:2] = 14'(32'he000 >> 2);
        else if (sel == 9) ra[15:2] = 14'(32'he004 >> 2);
        else if (sel == 10) ra[15:2] = 14'(32'hf000 >> 2);
        else if (sel == 11) ra[15:2] = 14'(32'hf020 >> 2);
        else if (sel == 12) ra[15:2] = 14'(32'hf030 >> 2);
        else ra[15:2] = 14'($urandom);
      end
      acc($urandom_range(0, 3) != 0, ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom),
          ra, $urandom);
    end
    reset = 1'b0;
    acc(0, 4'h0, 32'h0, 32'h0);
    @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
